// File: rtl/restoring_divider.sv
`default_nettype none
// ============================================================================
// Module   : restoring_divider
// Brief    : Sequential shift-subtract divider, one quotient bit per 2 cycles.
//            Define DIV_SIGNED_EN for two's-complement operands and results.
// Revision : 1.0 - initial release
// ============================================================================
module restoring_divider #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LOAD     = 3'd1,
        S_SHIFT    = 3'd2,
        S_SUBTRACT = 3'd3,
        S_DONE     = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH:0]     a_q;
    logic [WIDTH-1:0]   q_q;
    logic [WIDTH-1:0]   m_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   quot_q;
    logic [WIDTH-1:0]   rem_q;
    logic               dbz_q;

    logic [WIDTH:0]     w_diff;
    logic [WIDTH:0]     w_a_upd;
    logic [WIDTH-1:0]   w_q_upd;
    logic               w_last;
    logic [WIDTH-1:0]   w_mag_dvd;
    logic [WIDTH-1:0]   w_mag_dvs;
    logic [WIDTH-1:0]   w_dbz_rem;
    logic [WIDTH-1:0]   w_quot;
    logic [WIDTH-1:0]   w_rem;

    assign w_diff  = a_q - {1'b0, m_q};
    assign w_q_upd = {q_q[WIDTH-1:1], ~w_diff[WIDTH]};
    assign w_a_upd = w_diff[WIDTH] ? a_q : w_diff;
    assign w_last  = (cnt_q == CNT_W'(1));

`ifdef DIV_SIGNED_EN
    logic sn_q;
    logic sd_q;

    // Iterate on magnitudes; signs are reapplied only when results are written.
    assign w_mag_dvd = dividend[WIDTH-1] ? -dividend : dividend;
    assign w_mag_dvs = divisor[WIDTH-1]  ? -divisor  : divisor;
    assign w_dbz_rem = sn_q ? -q_q : q_q;
    assign w_quot    = (sn_q ^ sd_q) ? -w_q_upd : w_q_upd;
    assign w_rem     = sn_q ? -w_a_upd[WIDTH-1:0] : w_a_upd[WIDTH-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sn_q <= 1'b0;
            sd_q <= 1'b0;
        end else if (state_q == S_IDLE && start) begin
            sn_q <= dividend[WIDTH-1];
            sd_q <= divisor[WIDTH-1];
        end
    end
`else
    assign w_mag_dvd = dividend;
    assign w_mag_dvs = divisor;
    assign w_dbz_rem = q_q;
    assign w_quot    = w_q_upd;
    assign w_rem     = w_a_upd[WIDTH-1:0];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        busy    = 1'b1;
        done    = 1'b0;
        case (state_q)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD:     state_d = (m_q == '0) ? S_DONE : S_SHIFT;
            S_SHIFT:    state_d = S_SUBTRACT;
            S_SUBTRACT: state_d = w_last ? S_DONE : S_SHIFT;
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default:    state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q    <= '0;
            q_q    <= '0;
            m_q    <= '0;
            cnt_q  <= '0;
            quot_q <= '0;
            rem_q  <= '0;
            dbz_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        q_q <= w_mag_dvd;
                        m_q <= w_mag_dvs;
                    end
                end
                S_LOAD: begin
                    a_q   <= '0;
                    cnt_q <= CNT_W'(WIDTH);
                    if (m_q == '0) begin
                        quot_q <= '1;
                        rem_q  <= w_dbz_rem;
                        dbz_q  <= 1'b1;
                    end
                end
                S_SHIFT: begin
                    a_q <= {a_q[WIDTH-1:0], q_q[WIDTH-1]};
                    q_q <= {q_q[WIDTH-2:0], 1'b0};
                end
                S_SUBTRACT: begin
                    a_q   <= w_a_upd;
                    q_q   <= w_q_upd;
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (w_last) begin
                        quot_q <= w_quot;
                        rem_q  <= w_rem;
                        dbz_q  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule
`default_nettype wire

// File: tb/tb_restoring_divider.sv
`default_nettype none
// ============================================================================
// Module   : tb_restoring_divider
// Brief    : Self-checking bench for restoring_divider against a divide/modulo
//            reference model; directed cases plus randomized operands.
// Revision : 1.0 - initial release
// ============================================================================
module tb_restoring_divider;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int           n_checks = 0;
    int           n_errors = 0;
    logic [W-1:0] prev_q;
    logic [W-1:0] prev_r;

    restoring_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference: plain integer division; SV int division truncates toward zero
    // and the remainder takes the dividend's sign, matching the signed rules.
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] eq, output logic [W-1:0] er,
                         output logic edz);
        int sa, sb, q, r;
`ifdef DIV_SIGNED_EN
        sa = int'($signed(a));
        sb = int'($signed(b));
`else
        sa = int'(a);
        sb = int'(b);
`endif
        if (b == '0) begin
            eq  = '1;
            er  = a;
            edz = 1'b1;
        end else begin
            q   = sa / sb;
            r   = sa % sb;
            eq  = W'(q);
            er  = W'(r);
            edz = 1'b0;
        end
    endtask

    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit inj);
        logic [W-1:0] eq, er;
        logic         edz;
        int           lat, elat;
        model(a, b, eq, er, edz);
        elat = (b == '0) ? 1 : 2 * W + 1;
        @(negedge clk);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = W'($urandom);
        divisor  = W'($urandom);
        check("busy_run", {31'd0, busy}, 32'd1);
        lat = 0;
        while (!done && lat < 60) begin
            @(posedge clk);
            #1;
            lat++;
            if (lat == 5) begin
                check("hold_q", {24'd0, quotient}, {24'd0, prev_q});
                check("hold_r", {24'd0, remainder}, {24'd0, prev_r});
            end
            if (inj && lat == 4) begin
                start    = 1'b1;
                dividend = 8'd10;
                divisor  = 8'd2;
            end else begin
                start = 1'b0;
            end
        end
        check("latency", lat, elat);
        check("quotient", {24'd0, quotient}, {24'd0, eq});
        check("remainder", {24'd0, remainder}, {24'd0, er});
        check("div_by_zero", {31'd0, div_by_zero}, {31'd0, edz});
        // start during the DONE cycle must be ignored
        @(negedge clk);
        start    = 1'b1;
        dividend = W'($urandom);
        divisor  = W'($urandom);
        @(posedge clk);
        #1;
        start = 1'b0;
        check("done_pulse", {31'd0, done}, 32'd0);
        check("idle_after", {31'd0, busy}, 32'd0);
        check("result_kept", {24'd0, quotient}, {24'd0, eq});
        prev_q = eq;
        prev_r = er;
    endtask

    initial begin
        bit saw_done;
        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        prev_q   = '0;
        prev_r   = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_q", {24'd0, quotient}, 32'd0);
        check("rst_r", {24'd0, remainder}, 32'd0);
        check("rst_dbz", {31'd0, div_by_zero}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        do_op(8'd100, 8'd7, 1'b0);
        do_op(8'd255, 8'd1, 1'b0);
        do_op(8'd5, 8'd9, 1'b0);
        do_op(8'd42, 8'd0, 1'b0);
        do_op(8'd9, 8'd3, 1'b0);
        do_op(8'd200, 8'd13, 1'b1);
`ifdef DIV_SIGNED_EN
        do_op(8'h9C, 8'd7, 1'b0);
        do_op(8'd100, 8'hF9, 1'b0);
        do_op(8'h80, 8'hFF, 1'b0);
        do_op(8'h80, 8'd0, 1'b0);
`endif

        // Reset in the middle of an operation aborts it with no done pulse.
        @(negedge clk);
        start    = 1'b1;
        dividend = 8'd200;
        divisor  = 8'd13;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_q", {24'd0, quotient}, 32'd0);
        check("abort_r", {24'd0, remainder}, 32'd0);
        check("abort_dbz", {31'd0, div_by_zero}, 32'd0);
        saw_done = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (done) saw_done = 1'b1;
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (done) saw_done = 1'b1;
        end
        check("abort_no_done", {31'd0, saw_done}, 32'd0);
        prev_q = '0;
        prev_r = '0;
        do_op(8'd50, 8'd5, 1'b0);

        for (int i = 0; i < 40; i++) begin
            logic [W-1:0] ra, rb;
            ra = W'($urandom);
            rb = (i % 8 == 0) ? W'(0) : W'($urandom);
            do_op(ra, rb, ($urandom_range(0, 3) == 0));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/restoring_divider.md
Name: restoring_divider

Overview:
- Sequential restoring (shift-subtract) divider with an integrated control FSM and datapath.
- Unsigned WIDTH-bit dividend / divisor -> WIDTH-bit quotient and remainder; one quotient bit per 2 clock cycles.
- Inverse companion to the shift-add multiplier; sits beside it in the arithmetic unit, driven by the same start/done style sequencer.

Parameters:
WIDTH, 8, operand/result width in bits (>= 2)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only in IDLE
dividend  input  WIDTH  numerator; captured on the start-sampling edge
divisor  input  WIDTH  denominator; captured on the start-sampling edge
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse; results valid while high and held after
quotient  output  WIDTH  registered result
remainder  output  WIDTH  registered result
div_by_zero  output  1  registered flag; updated with results

Behaviour:
- One clock; reset is asynchronous and active-low. rst_n low -> state IDLE; busy=0, done=0, quotient=0, remainder=0, div_by_zero=0; all internal registers cleared. Reset mid-operation aborts immediately, and no done is produced.
- Internal registers: A (WIDTH+1 bits, partial remainder), Q (WIDTH), M (WIDTH), cnt (clog2(WIDTH)+1 bits).
- States: IDLE, LOAD, SHIFT, SUBTRACT, DONE.
- IDLE: if start=1 then capture dividend->Q and divisor->M, and go to LOAD. Otherwise stay.
- LOAD: A=0, cnt=WIDTH.
  - If M==0: go to DONE; quotient={WIDTH{1}}, remainder=captured dividend, div_by_zero=1.
  - Else: go to SHIFT.
- SHIFT: {A,Q} <<= 1 (Q[0]<=0). Go to SUBTRACT.
- SUBTRACT: diff=A-{0,M} (WIDTH+1 bits).
  - If diff MSB=0: A<=diff, Q[0]<=1.
  - Else: A unchanged (restore), Q[0] stays 0.
  - cnt<=cnt-1.
  - If cnt==1: go to DONE and write quotient/remainder from the post-update Q/A[WIDTH-1:0], with div_by_zero<=0.
  - Else: go to SHIFT.
- DONE: done=1 for exactly one cycle (Moore output). Next state is IDLE.
- quotient, remainder and div_by_zero change only on transitions into DONE. They hold until the next operation reaches DONE.
- Latency, counted in rising edges after the start-sampling edge until done is high:
  - normal: 2*WIDTH+1 (17 for WIDTH=8)
  - divide-by-zero: 1
- start while busy=1 is ignored, and operands are not re-captured. start high in the DONE cycle is ignored. start high in IDLE right after DONE is accepted (back-to-back throughput is 2*WIDTH+3 cycles).
- Operands may change freely after the capture edge.
- Unreachable state encodings recover to IDLE.

Optional Feature:
Macro DIV_SIGNED_EN.
- Defined: operands and results are two's complement.
  - The capture edge stores magnitudes plus the sign bits of dividend and divisor.
  - The iteration is unchanged.
  - On the write into DONE: quotient is negated if the signs differ; remainder takes the dividend's sign (negated if the dividend is negative).
  - Divide-by-zero: quotient={WIDTH{1}} (-1), remainder=dividend.
  - Overflow case (most-negative / -1) wraps: quotient = most-negative value, remainder=0, with no flag.
  - Latency is identical to unsigned.
- Undefined: purely unsigned. No sign logic is synthesized.

Test Plan:
- WIDTH=8, reset released, start with 100/7 -> done exactly 17 edges after the sampling edge; quotient=14, remainder=2, div_by_zero=0, busy=0 after done.
- 255/1 then, back-to-back, 5/9 -> first result q=255 r=0; second q=0 r=5. The first results hold until the second done.
- 42/0 -> done 1 edge after sampling; quotient=0xFF, remainder=42, div_by_zero=1. Then 9/3 clears the flag: q=3 r=0.
- Start 200/13, pulse start again at cycle 5 with 10/2 -> second request ignored; result q=15 r=5.
- Start 200/13, assert rst_n=0 at cycle 8 -> outputs immediately 0, state IDLE, no done pulse. After release, 50/5 gives q=10 r=0.
- With DIV_SIGNED_EN: -100/7 -> quotient=0xF2 (-14), remainder=0xFE (-2); 100/-7 -> q=0xF2, r=2; -128/-1 -> q=0x80, r=0.
